// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the DRAM port arbiter.
//   arb_state_t       : arbiter mode, free round-robin or held by a lock owner
//   LOCK_IDLE_TIMEOUT : owner idle cycles after which a lock is dropped
//   req_id_w()        : width of a requester index for a given requester count
package gpu_mem_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int IDLE_CNT_W = 4;
    localparam int LOCK_IDLE_TIMEOUT = 16;
    localparam logic [IDLE_CNT_W-1:0] IDLE_CNT_LAST = IDLE_CNT_W'(LOCK_IDLE_TIMEOUT - 1);

    // Width of a requester index. It is never narrower than one bit.
    function automatic int req_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   valid : request vector
//   ptr   : index of the previous winner; the search starts at ptr+1
//   grant : one-hot winner, or zero if nothing is valid
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Walk the offsets 1..NUM_REQ from the pointer. The first valid
    // requester wins. The compare against i keeps every bit select constant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && valid[i] && (i == ((int'(ptr) + off) % NUM_REQ))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares a single DRAM command port among NUM_REQ requesters.
// Arbitration is round-robin. A requester can optionally lock the port for an
// atomic sequence. Read data comes back after a fixed latency and is routed
// to the requester that issued the read.
//   i_req_*      : per-requester request bundle (addr/wdata flattened)
//   o_req_ready  : one-hot grant; a request is accepted when valid & ready
//   o_rsp_*      : one-hot read response strobe plus shared read data
//   i_dram_ready : DRAM command acceptance (low during refresh)
//   o_dram_*     : registered DRAM command; i_dram_rdata returns read data
module dram_port_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ-1:0]            i_req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    input  logic                          i_dram_ready,
    output logic                          o_dram_we,
    output logic                          o_dram_re,
    output logic [ADDR_WIDTH-1:0]         o_dram_addr,
    output logic [DATA_WIDTH-1:0]         o_dram_wdata,
    input  logic [DATA_WIDTH-1:0]         i_dram_rdata
);

    localparam int ID_W   = req_id_w(NUM_REQ);
    localparam int PIPE_D = RD_LATENCY + 1;

    arb_state_t            state_reg, state_next;
    logic [ID_W-1:0]       last_grant_reg, last_grant_next;
    logic [ID_W-1:0]       lock_owner_reg, lock_owner_next;
    logic [IDLE_CNT_W-1:0] idle_cnt_reg, idle_cnt_next;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [NUM_REQ-1:0]    accept;
    logic                  any_accept;
    logic [ID_W-1:0]       accept_id;
    logic                  accept_we;
    logic                  accept_lock;
    logic [ADDR_WIDTH-1:0] accept_addr;
    logic [DATA_WIDTH-1:0] accept_wdata;

    // Slot k holds a read that was issued k+1 cycles ago. The last slot
    // lines up with i_dram_rdata.
    logic [PIPE_D-1:0]     pipe_valid_reg;
    logic [ID_W-1:0]       pipe_id_reg [PIPE_D];

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid (i_req_valid),
        .ptr   (last_grant_reg),
        .grant (pick_grant)
    );

    // While the port is locked, only the owner can see ready.
    always_comb begin
        o_req_ready = '0;
        if (i_dram_ready) begin
            if (state_reg == ARB) begin
                o_req_ready = pick_grant;
            end else begin
                o_req_ready[lock_owner_reg] = i_req_valid[lock_owner_reg];
            end
        end
    end

    assign accept     = i_req_valid & o_req_ready;
    assign any_accept = |accept;

    // Encode the one-hot accept and select the request fields of the winner.
    always_comb begin
        accept_id    = '0;
        accept_we    = 1'b0;
        accept_lock  = 1'b0;
        accept_addr  = '0;
        accept_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                accept_id    = ID_W'(i);
                accept_we    = i_req_we[i];
                accept_lock  = i_req_lock[i];
                accept_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                accept_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        lock_owner_next = lock_owner_reg;
        idle_cnt_next   = idle_cnt_reg;

        if (any_accept) begin
            last_grant_next = accept_id;
        end

        case (state_reg)
            ARB: begin
                if (any_accept && accept_lock) begin
                    state_next      = LOCKED;
                    lock_owner_next = accept_id;
                    idle_cnt_next   = '0;
                end
            end
            LOCKED: begin
                // Any accept here must come from the owner. If the owner is
                // valid but stalled by DRAM refresh, it is not counted as idle.
                if (any_accept) begin
                    idle_cnt_next = '0;
                    if (!accept_lock) begin
                        state_next = ARB;
                    end
                end else if (i_req_valid[lock_owner_reg]) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg == IDLE_CNT_LAST) begin
                    state_next    = ARB;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            lock_owner_reg <= '0;
            idle_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            lock_owner_reg <= lock_owner_next;
            idle_cnt_reg   <= idle_cnt_next;
        end
    end

    // The strobes last one cycle. Address and write data keep the value of
    // the last accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dram_we    <= 1'b0;
            o_dram_re    <= 1'b0;
            o_dram_addr  <= '0;
            o_dram_wdata <= '0;
        end else begin
            o_dram_we <= any_accept & accept_we;
            o_dram_re <= any_accept & ~accept_we;
            if (any_accept) begin
                o_dram_addr  <= accept_addr;
                o_dram_wdata <= accept_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
            for (int k = 0; k < PIPE_D; k++) begin
                pipe_id_reg[k] <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= any_accept & ~accept_we;
            pipe_id_reg[0]    <= accept_id;
            for (int k = 1; k < PIPE_D; k++) begin
                pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                pipe_id_reg[k]    <= pipe_id_reg[k-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign o_rsp_valid[gi] = pipe_valid_reg[RD_LATENCY] &&
                                     (pipe_id_reg[RD_LATENCY] == ID_W'(gi));
        end
    endgenerate

    assign o_rsp_rdata = i_dram_rdata;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter. Two instances share the request
// inputs. u_dut1 uses RD_LATENCY=1 and u_dut3 uses RD_LATENCY=3. Each has a
// DRAM model that returns (address ^ RD_KEY) after the configured latency.
module tb_dram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic            dram_ready = 1'b1;

    logic [N-1:0]    ready1, rsp_valid1, ready3, rsp_valid3;
    logic [DW-1:0]   rsp_rdata1, rsp_rdata3, dram_rdata1, dram_rdata3;
    logic            dram_we1, dram_re1, dram_we3, dram_re3;
    logic [AW-1:0]   dram_addr1, dram_addr3;
    logic [DW-1:0]   dram_wdata1, dram_wdata3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_lock(req_lock),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(ready1), .o_rsp_valid(rsp_valid1), .o_rsp_rdata(rsp_rdata1),
        .i_dram_ready(dram_ready), .o_dram_we(dram_we1), .o_dram_re(dram_re1),
        .o_dram_addr(dram_addr1), .o_dram_wdata(dram_wdata1), .i_dram_rdata(dram_rdata1)
    );

    dram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_lock(req_lock),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(ready3), .o_rsp_valid(rsp_valid3), .o_rsp_rdata(rsp_rdata3),
        .i_dram_ready(dram_ready), .o_dram_we(dram_we3), .o_dram_re(dram_re3),
        .o_dram_addr(dram_addr3), .o_dram_wdata(dram_wdata3), .i_dram_rdata(dram_rdata3)
    );

    // DRAM models: the address captured at the end of a command cycle is
    // returned RD_LATENCY cycles after that command.
    logic [AW-1:0] hist1;
    logic [AW-1:0] hist3 [3];
    always @(posedge clk) begin
        hist1    <= dram_addr1;
        hist3[0] <= dram_addr3;
        hist3[1] <= hist3[0];
        hist3[2] <= hist3[1];
    end
    assign dram_rdata1 = hist1 ^ RD_KEY;
    assign dram_rdata3 = hist3[2] ^ RD_KEY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic we, input logic lk,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[k] = v;
        req_we[k]    = we;
        req_lock[k]  = lk;
        req_addr[k*AW +: AW]  = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic test_reset();
        set_req(0, 0, 0, 0, 32'h0, 32'h0);
        set_req(1, 0, 0, 0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready1, rsp_valid1, dram_we1, dram_re1, dram_addr1, dram_wdata1} !== '0) begin
            $display("FAIL reset_outputs_dut1 got ready=%b rsp=%b we=%b re=%b addr=%h wdata=%h required all zero",
                     ready1, rsp_valid1, dram_we1, dram_re1, dram_addr1, dram_wdata1);
            n_err++;
        end
        n_cmp++;
        if ({ready3, rsp_valid3, dram_we3, dram_re3, dram_addr3, dram_wdata3} !== '0) begin
            $display("FAIL reset_outputs_dut3 got ready=%b rsp=%b we=%b re=%b addr=%h wdata=%h required all zero",
                     ready3, rsp_valid3, dram_we3, dram_re3, dram_addr3, dram_wdata3);
            n_err++;
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({ready1, rsp_valid1, dram_we1, dram_re1} !== '0) begin
            $display("FAIL post_reset_idle got ready=%b rsp=%b we=%b re=%b required all zero",
                     ready1, rsp_valid1, dram_we1, dram_re1);
            n_err++;
        end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready, exp_rsp;
        logic [31:0] exp_addr;
        set_req(0, 1, 0, 0, 32'h10, 32'h0);
        set_req(1, 1, 0, 0, 32'h20, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 8) req_valid = '0;
            #1;
            exp_ready = (i < 8) ? (((i % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_cmp++;
            if (ready1 !== exp_ready) begin
                $display("FAIL rr_ready cyc=%0d got=%b required=%b", i, ready1, exp_ready);
                n_err++;
            end
            if (i >= 1 && i <= 8) begin
                exp_addr = (((i - 1) % 2) == 0) ? 32'h10 : 32'h20;
                n_cmp++;
                if ({dram_re1, dram_we1, dram_addr1} !== {1'b1, 1'b0, exp_addr}) begin
                    $display("FAIL rr_cmd cyc=%0d got re=%b we=%b addr=%h required re=1 we=0 addr=%h",
                             i, dram_re1, dram_we1, dram_addr1, exp_addr);
                    n_err++;
                end
            end
            exp_rsp = (i >= 2) ? ((((i - 2) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_cmp++;
            if (rsp_valid1 !== exp_rsp) begin
                $display("FAIL rr_rsp_valid cyc=%0d got=%b required=%b", i, rsp_valid1, exp_rsp);
                n_err++;
            end
            if (i >= 2) begin
                exp_addr = ((((i - 2) % 2) == 0) ? 32'h10 : 32'h20) ^ RD_KEY;
                n_cmp++;
                if (rsp_rdata1 !== exp_addr) begin
                    $display("FAIL rr_rsp_data cyc=%0d got=%h required=%h", i, rsp_rdata1, exp_addr);
                    n_err++;
                end
            end
            $display("rr cyc=%0d ready=%b rsp=%b", i, ready1, rsp_valid1);
            tick();
        end
    endtask

    task automatic test_lock();
        logic [1:0]  v_tab [8];
        logic [1:0]  rdy_tab [8];
        logic [1:0]  rsp_tab [8];
        logic [31:0] exp_data;
        v_tab   = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
        rdy_tab = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        rsp_tab = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int c = 0; c < 8; c++) begin
            set_req(0, v_tab[c][0], 0, 0, 32'h10, 32'h0);
            set_req(1, v_tab[c][1], (c == 0), (c < 4), (c == 0) ? 32'h40 : 32'h44, 32'hDEADBEEF);
            #1;
            n_cmp++;
            if (ready1 !== rdy_tab[c]) begin
                $display("FAIL lock_ready cyc=%0d got=%b required=%b", c, ready1, rdy_tab[c]);
                n_err++;
            end
            if (c == 1) begin
                n_cmp++;
                if ({dram_we1, dram_re1, dram_addr1, dram_wdata1} !== {1'b1, 1'b0, 32'h40, 32'hDEADBEEF}) begin
                    $display("FAIL lock_write_cmd got we=%b re=%b addr=%h wdata=%h required we=1 re=0 addr=00000040 wdata=deadbeef",
                             dram_we1, dram_re1, dram_addr1, dram_wdata1);
                    n_err++;
                end
            end
            n_cmp++;
            if (rsp_valid1 !== rsp_tab[c]) begin
                $display("FAIL lock_rsp_valid cyc=%0d got=%b required=%b", c, rsp_valid1, rsp_tab[c]);
                n_err++;
            end
            if (rsp_tab[c] != 2'b00) begin
                exp_data = ((rsp_tab[c] == 2'b01) ? 32'h10 : 32'h44) ^ RD_KEY;
                n_cmp++;
                if (rsp_rdata1 !== exp_data) begin
                    $display("FAIL lock_rsp_data cyc=%0d got=%h required=%h", c, rsp_rdata1, exp_data);
                    n_err++;
                end
            end
            $display("lock cyc=%0d valid=%b ready=%b rsp=%b", c, req_valid, ready1, rsp_valid1);
            tick();
        end
        set_req(1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_idle_timeout();
        logic [1:0] exp_ready;
        for (int e = 0; e < 19; e++) begin
            set_req(1, (e == 0), 0, (e == 0), 32'h48, 32'h0);
            set_req(0, (e >= 1 && e <= 17), 0, 0, 32'h10, 32'h0);
            #1;
            exp_ready = (e == 0) ? 2'b10 : ((e == 17) ? 2'b01 : 2'b00);
            n_cmp++;
            if (ready1 !== exp_ready) begin
                $display("FAIL idle_ready cyc=%0d got=%b required=%b", e, ready1, exp_ready);
                n_err++;
            end
            $display("idle cyc=%0d valid=%b ready=%b", e, req_valid, ready1);
            tick();
        end
    endtask

    task automatic test_dram_stall();
        logic [1:0] exp_ready;
        for (int j = 0; j < 8; j++) begin
            dram_ready = (j >= 5);
            set_req(0, (j < 7), 0, 0, 32'h10, 32'h0);
            set_req(1, (j < 7), 0, 0, 32'h20, 32'h0);
            #1;
            exp_ready = (j < 5) ? 2'b00 : ((j == 5) ? 2'b10 : ((j == 6) ? 2'b01 : 2'b00));
            n_cmp++;
            if (ready1 !== exp_ready) begin
                $display("FAIL stall_ready cyc=%0d got=%b required=%b", j, ready1, exp_ready);
                n_err++;
            end
            n_cmp++;
            if (j <= 5) begin
                if ({dram_re1, dram_we1} !== 2'b00) begin
                    $display("FAIL stall_strobe cyc=%0d got re=%b we=%b required re=0 we=0", j, dram_re1, dram_we1);
                    n_err++;
                end
            end else begin
                if ({dram_re1, dram_addr1} !== {1'b1, ((j == 6) ? 32'h20 : 32'h10)}) begin
                    $display("FAIL stall_resume_cmd cyc=%0d got re=%b addr=%h required re=1 addr=%h",
                             j, dram_re1, dram_addr1, (j == 6) ? 32'h20 : 32'h10);
                    n_err++;
                end
            end
            $display("stall cyc=%0d dram_ready=%b ready=%b re=%b", j, dram_ready, ready1, dram_re1);
            tick();
        end
        dram_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_rsp;
        logic [31:0] exp_data;
        for (int t = 0; t < 9; t++) begin
            set_req(0, (t < 4), 0, 0, 32'h100 + 32'(4 * t), 32'h0);
            set_req(1, 0, 0, 0, 32'h0, 32'h0);
            #1;
            n_cmp++;
            if (ready1 !== ((t < 4) ? 2'b01 : 2'b00)) begin
                $display("FAIL b2b_ready cyc=%0d got=%b required=%b", t, ready1, (t < 4) ? 2'b01 : 2'b00);
                n_err++;
            end
            if (t >= 1) begin
                exp_rsp = (t >= 2 && t <= 5) ? 2'b01 : 2'b00;
                n_cmp++;
                if (rsp_valid1 !== exp_rsp) begin
                    $display("FAIL b2b_rsp_valid_lat1 cyc=%0d got=%b required=%b", t, rsp_valid1, exp_rsp);
                    n_err++;
                end
                if (exp_rsp != 2'b00) begin
                    exp_data = (32'h100 + 32'(4 * (t - 2))) ^ RD_KEY;
                    n_cmp++;
                    if (rsp_rdata1 !== exp_data) begin
                        $display("FAIL b2b_rsp_data_lat1 cyc=%0d got=%h required=%h", t, rsp_rdata1, exp_data);
                        n_err++;
                    end
                end
            end
            if (t >= 3) begin
                exp_rsp = (t >= 4 && t <= 7) ? 2'b01 : 2'b00;
                n_cmp++;
                if (rsp_valid3 !== exp_rsp) begin
                    $display("FAIL b2b_rsp_valid_lat3 cyc=%0d got=%b required=%b", t, rsp_valid3, exp_rsp);
                    n_err++;
                end
                if (exp_rsp != 2'b00) begin
                    exp_data = (32'h100 + 32'(4 * (t - 4))) ^ RD_KEY;
                    n_cmp++;
                    if (rsp_rdata3 !== exp_data) begin
                        $display("FAIL b2b_rsp_data_lat3 cyc=%0d got=%h required=%h", t, rsp_rdata3, exp_data);
                        n_err++;
                    end
                end
            end
            $display("b2b cyc=%0d ready=%b rsp1=%b rsp3=%b", t, ready1, rsp_valid1, rsp_valid3);
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        set_req(0, 0, 0, 0, 32'h10, 32'h0);
        set_req(1, 1, 0, 1, 32'h80, 32'h0);
        for (int m = 0; m < 2; m++) begin
            #1;
            n_cmp++;
            if (ready1 !== 2'b10) begin
                $display("FAIL midrst_issue_ready cyc=%0d got=%b required=10", m, ready1);
                n_err++;
            end
            tick();
        end
        rst_n = 1'b0;
        set_req(1, 0, 0, 0, 32'h80, 32'h0);
        #1;
        n_cmp++;
        if ({ready1, rsp_valid1, dram_we1, dram_re1, dram_addr1, dram_wdata1,
             ready3, rsp_valid3, dram_we3, dram_re3, dram_addr3, dram_wdata3} !== '0) begin
            $display("FAIL midrst_outputs got rsp1=%b re1=%b addr1=%h rsp3=%b re3=%b addr3=%h required all zero",
                     rsp_valid1, dram_re1, dram_addr1, rsp_valid3, dram_re3, dram_addr3);
            n_err++;
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if ({rsp_valid1, rsp_valid3} !== 4'b0000) begin
                $display("FAIL midrst_stale_rsp cyc=%0d got rsp1=%b rsp3=%b required 00 00", k, rsp_valid1, rsp_valid3);
                n_err++;
            end
        end
        set_req(0, 1, 0, 0, 32'h10, 32'h0);
        set_req(1, 1, 0, 0, 32'h20, 32'h0);
        #1;
        n_cmp++;
        if ({ready1, ready3} !== 4'b0101) begin
            $display("FAIL midrst_first_grant got ready1=%b ready3=%b required 01 01", ready1, ready3);
            n_err++;
        end
        $display("midrst first grant ready1=%b ready3=%b", ready1, ready3);
        tick();
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_idle_timeout();
        test_dram_stall();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
